// File: rtl/kan_pkg.sv
// Shared constants and types for the KAN layer bridge: element width, lane
// count, lane index type and the bridge state encoding.
package kan_pkg;

  localparam int KAN_IN_W   = 64;
  localparam int KAN_ELEM_W = 16;
  localparam int KAN_LANES  = KAN_IN_W / KAN_ELEM_W;
  localparam int KAN_LANE_W = (KAN_LANES > 1) ? $clog2(KAN_LANES) : 1;

  typedef logic [KAN_LANE_W-1:0] lane_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/kan_layer_bridge.sv
// Width bridge from the KAN 64-bit output stream to its 16-bit input stream:
// emits one element per beat LSB-first, generates tlast from layersize and flags upstream tlast mismatches.
module kan_layer_bridge
  import kan_pkg::*;
#(
  parameter int S_AXIS_DATAWIDTH = 64,
  parameter int M_AXIS_DATAWIDTH = 16,
  parameter int LG_LAYERSIZE     = 12
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_areset,
  input  logic [S_AXIS_DATAWIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [M_AXIS_DATAWIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  input  logic [LG_LAYERSIZE-1:0]     layersize,
  output logic                        err_len
);

  localparam int LANES  = S_AXIS_DATAWIDTH / M_AXIS_DATAWIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t                      r_state;
  logic [S_AXIS_DATAWIDTH-1:0] r_hold;
  logic [LANE_W-1:0]           r_lane;
  logic [LG_LAYERSIZE-1:0]     r_elem_cnt;
  logic [LG_LAYERSIZE-1:0]     r_eff_size;
  logic                        r_err_len;
  logic                        r_tvalid;
  logic                        r_tlast;
  logic [M_AXIS_DATAWIDTH-1:0] r_tdata;

  logic                        w_out_acc;
  logic                        w_in_acc;
  logic                        w_s_ready;
  logic                        w_exp_last;
  logic                        w_tlast_n;
  logic [LG_LAYERSIZE-1:0]     w_cnt_n;
  logic [LG_LAYERSIZE-1:0]     w_eff_n;
  logic [LG_LAYERSIZE-1:0]     w_eff_m1;
  logic [LG_LAYERSIZE-1:0]     w_word_end;
  logic [LANE_W-1:0]           w_lane_nx;
  logic [M_AXIS_DATAWIDTH-1:0] w_next_elem;

  // Handshakes and next counter values; w_cnt_n is the count after this cycle's output accept
  always_comb begin
    w_out_acc   = r_tvalid && m_axis_tready;
    w_lane_nx   = r_lane + LANE_W'(1);
    w_next_elem = r_hold[w_lane_nx*M_AXIS_DATAWIDTH +: M_AXIS_DATAWIDTH];
    if (s_axis_areset) begin
      w_s_ready = 1'b0;
    end else if (r_state == IDLE) begin
      w_s_ready = 1'b1;
    end else begin
      w_s_ready = (r_lane == LAST_LANE) && m_axis_tready;
    end
    w_in_acc = s_axis_tvalid && w_s_ready;
    if (w_out_acc) begin
      if (r_tlast) begin
        w_cnt_n = '0;
      end else begin
        w_cnt_n = r_elem_cnt + LG_LAYERSIZE'(1);
      end
    end else begin
      w_cnt_n = r_elem_cnt;
    end
    // Size is latched only when a vector starts; a zero size wraps to the full counter range
    if (w_in_acc && (w_cnt_n == '0)) begin
      w_eff_n = {layersize[LG_LAYERSIZE-1:2], 2'b00};
    end else begin
      w_eff_n = r_eff_size;
    end
    w_eff_m1   = w_eff_n - LG_LAYERSIZE'(1);
    w_tlast_n  = (w_cnt_n == w_eff_m1);
    w_word_end = w_cnt_n + LG_LAYERSIZE'(LANES);
    w_exp_last = (w_word_end == w_eff_n);
  end

  // Bridge FSM, element counter and sticky length-error flag
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_lane     <= '0;
      r_elem_cnt <= '0;
      r_eff_size <= '0;
      r_err_len  <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
    end else begin
      r_elem_cnt <= w_cnt_n;
      r_eff_size <= w_eff_n;
      if (w_in_acc && (s_axis_tlast != w_exp_last)) begin
        r_err_len <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_in_acc) begin
            r_hold   <= s_axis_tdata;
            r_lane   <= '0;
            r_tdata  <= s_axis_tdata[M_AXIS_DATAWIDTH-1:0];
            r_tvalid <= 1'b1;
            r_tlast  <= w_tlast_n;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (w_out_acc) begin
            if (r_lane != LAST_LANE) begin
              r_lane  <= w_lane_nx;
              r_tdata <= w_next_elem;
              r_tlast <= w_tlast_n;
            end else if (w_in_acc) begin
              r_hold  <= s_axis_tdata;
              r_lane  <= '0;
              r_tdata <= s_axis_tdata[M_AXIS_DATAWIDTH-1:0];
              r_tlast <= w_tlast_n;
            end else begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign err_len       = r_err_len;

endmodule

// File: tb/tb_kan_layer_bridge.sv
// Directed bench for kan_layer_bridge: streams, stalls, length errors,
// mid-vector reset and layer-size latching.
module tb_kan_layer_bridge;

  logic        clk = 1'b0;
  logic        areset;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_ready;
  logic [11:0] layersize;
  logic        err_len;

  int errors = 0;
  int checks = 0;

  logic [63:0] g_beat[8];
  logic        g_blast[8];
  logic        g_exp_last[32];
  int          g_ls_switch_at;
  logic [11:0] g_ls2;
  int          acc_cyc[8];
  int          first_out;
  int          last_out;
  int          err_cyc;

  localparam logic [63:0] BEAT_A = 64'h0004_0003_0002_0001;
  localparam logic [63:0] BEAT_B = 64'h0008_0007_0006_0005;
  localparam logic [63:0] BEAT_C = 64'h800C_000B_FFFF_7FFF;

  always #5 clk = ~clk;

  kan_layer_bridge dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_ready),
    .layersize     (layersize),
    .err_len       (err_len)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 32; i++) g_exp_last[i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      g_beat[i]  = 64'h0;
      g_blast[i] = 1'b0;
      acc_cyc[i] = -1;
    end
    g_ls_switch_at = -1;
    g_ls2 = 12'd0;
  endtask

  // Feed nbeats beats and check nelem outputs; mode 0: ready always, mode 1: ready toggles
  task automatic stream(input string tag, input int nbeats, input int nelem, input int mode);
    int          bi;
    int          ei;
    int          cyc;
    logic        stalled;
    logic        sw;
    logic [15:0] hd;
    logic        hl;
    logic [15:0] exp_d;
    bi = 0; ei = 0; cyc = 0; stalled = 1'b0; hd = 16'h0; hl = 1'b0;
    first_out = -1; last_out = -1; err_cyc = -1;
    while ((bi < nbeats || ei < nelem) && cyc < 100) begin
      s_tvalid = (bi < nbeats);
      s_tdata  = (bi < nbeats) ? g_beat[bi] : 64'h0;
      s_tlast  = (bi < nbeats) ? g_blast[bi] : 1'b0;
      m_ready  = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge clk);
      sw = 1'b0;
      if (stalled) begin
        chk({tag, "_stall_data"}, m_tdata, hd);
        chk({tag, "_stall_last"}, m_tlast, hl);
        chk({tag, "_stall_valid"}, m_tvalid, 1'b1);
      end
      if (m_tvalid && m_ready) begin
        if (ei < nelem) begin
          exp_d = g_beat[ei/4][(ei%4)*16 +: 16];
          chk($sformatf("%s_data%0d", tag, ei), m_tdata, exp_d);
          chk($sformatf("%s_last%0d", tag, ei), m_tlast, g_exp_last[ei]);
        end else begin
          chk({tag, "_extra_out"}, ei, nelem - 1);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        ei++;
        stalled = 1'b0;
      end else if (m_tvalid) begin
        stalled = 1'b1;
        hd = m_tdata;
        hl = m_tlast;
      end else begin
        stalled = 1'b0;
      end
      if (err_len && err_cyc < 0) err_cyc = cyc;
      if (s_tvalid && s_tready) begin
        acc_cyc[bi] = cyc;
        bi++;
        sw = (bi == g_ls_switch_at);
      end
      @(posedge clk); #2;
      if (sw) layersize = g_ls2;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 64'h0;
    m_ready  = 1'b1;
    chk({tag, "_elems_done"}, ei, nelem);
    chk({tag, "_beats_done"}, bi, nbeats);
  endtask

  initial begin
    areset = 1'b1; s_tdata = 64'h0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_ready = 1'b1; layersize = 12'd8;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_tdata", m_tdata, 16'h0);
    chk("rst_err", err_len, 1'b0);
    chk("rst_sready", s_tready, 1'b0);
    @(posedge clk); #2;
    areset = 1'b0;

    // Two-beat vector at full rate
    clear_vec();
    layersize = 12'd8;
    g_beat[0] = BEAT_A; g_blast[0] = 1'b0;
    g_beat[1] = BEAT_B; g_blast[1] = 1'b1;
    g_exp_last[7] = 1'b1;
    stream("full", 2, 8, 0);
    chk("full_first_out_cyc", first_out, 1);
    chk("full_last_out_cyc", last_out, 8);
    chk("full_accept_spacing", acc_cyc[1] - acc_cyc[0], 4);
    @(negedge clk);
    chk("full_idle_tvalid", m_tvalid, 1'b0);
    chk("full_err", err_len, 1'b0);
    @(posedge clk); #2;

    // Same vector with downstream stalls
    stream("stall", 2, 8, 1);
    chk("stall_err", err_len, 1'b0);

    // Missing upstream tlast raises the sticky error
    clear_vec();
    layersize = 12'd4;
    g_beat[0] = BEAT_C; g_blast[0] = 1'b0;
    g_exp_last[3] = 1'b1;
    stream("lenerr", 1, 4, 0);
    chk("lenerr_rise_cyc", err_cyc, 1);
    @(negedge clk);
    chk("lenerr_sticky", err_len, 1'b1);
    @(posedge clk); #2;

    // Reset after two elements discards the vector
    layersize = 12'd8;
    s_tvalid = 1'b1; s_tdata = BEAT_A; s_tlast = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    chk("mrst_sready_idle", s_tready, 1'b1);
    @(posedge clk); #2;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("mrst_elem0", m_tdata, 16'h0001);
    @(posedge clk); #2;
    @(negedge clk);
    chk("mrst_elem1", m_tdata, 16'h0002);
    @(posedge clk); #2;
    areset = 1'b1;
    @(negedge clk);
    chk("mrst_sready", s_tready, 1'b0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("mrst_tvalid", m_tvalid, 1'b0);
    chk("mrst_tdata", m_tdata, 16'h0);
    chk("mrst_err", err_len, 1'b0);
    @(posedge clk); #2;
    areset = 1'b0;
    clear_vec();
    g_beat[0] = BEAT_A; g_blast[0] = 1'b0;
    g_beat[1] = BEAT_B; g_blast[1] = 1'b1;
    g_exp_last[7] = 1'b1;
    stream("after_rst", 2, 8, 0);
    chk("after_rst_err", err_len, 1'b0);

    // Layer size change mid-vector applies only to the next vector
    clear_vec();
    layersize = 12'd8;
    g_beat[0] = BEAT_A; g_blast[0] = 1'b0;
    g_beat[1] = BEAT_B; g_blast[1] = 1'b1;
    g_beat[2] = BEAT_C; g_blast[2] = 1'b1;
    g_exp_last[7] = 1'b1;
    g_exp_last[11] = 1'b1;
    g_ls_switch_at = 1;
    g_ls2 = 12'd4;
    stream("lschg", 3, 12, 0);
    chk("lschg_err", err_len, 1'b0);

    // Low two size bits are ignored: 6 behaves as 4
    clear_vec();
    layersize = 12'd6;
    g_beat[0] = BEAT_A; g_blast[0] = 1'b1;
    g_beat[1] = BEAT_B; g_blast[1] = 1'b1;
    g_exp_last[3] = 1'b1;
    g_exp_last[7] = 1'b1;
    stream("ls6", 2, 8, 1);
    chk("ls6_err", err_len, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kan_layer_bridge.md
Name: kan_layer_bridge

Overview:
- Sits directly downstream of the KAN accelerator's 64-bit output stream.
- Splits each 64-bit beat into four signed 16-bit activations, emitted one per beat.
- Output feeds the accelerator's 16-bit input stream for layer chaining.
- Generates tlast from a programmed layer size and cross-checks it against the upstream tlast.

Parameters:
S_AXIS_DATAWIDTH, 64, input beat width; must be a multiple of M_AXIS_DATAWIDTH
M_AXIS_DATAWIDTH, 16, output element width
LG_LAYERSIZE, 12, width of the layer-size and element counters

Ports:
s_axis_aclk  in  1  single clock; all logic on rising edge
s_axis_areset  in  1  synchronous reset, active-high
s_axis_tdata  in  S_AXIS_DATAWIDTH  packed elements; element 0 in bits [15:0]
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  upstream end-of-vector marker
s_axis_tready  out  1  input beat accepted when tvalid && tready
m_axis_tdata  out  M_AXIS_DATAWIDTH  one element
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last element of the vector
m_axis_tready  in  1  downstream ready
layersize  in  LG_LAYERSIZE  elements per output vector; multiple of 4
err_len  out  1  sticky flag: upstream tlast disagreed with the element count

Behaviour:
- Reset (synchronous, active-high): the following are all 0 while reset is high.
  - State = IDLE; lane = 0; elem_cnt = 0; holding register = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, err_len = 0, s_axis_tready = 0.
- Reset mid-vector discards the held word and the partial count. No output is produced for it.
- States:
  - IDLE: no word held. s_axis_tready = 1. On input accept: load the word, lane = 0, go to EMIT.
  - EMIT: word held. m_axis_tvalid = 1 and m_axis_tdata = hold[lane*16 +: 16].
    - On output accept with lane < 3: lane++.
    - On output accept with lane == 3: if s_axis_tvalid, load the new word, lane = 0, stay in EMIT; otherwise go to IDLE.
  - In EMIT, s_axis_tready = (lane == 3) && m_axis_tready. This is combinational and allows back-to-back words with zero bubbles.
- Latency and throughput:
  - A word accepted in cycle N presents element 0 in cycle N+1.
  - Sustained rate is one element per cycle, so the input sees one beat accepted every 4 cycles.
- AXIS rules:
  - m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid && !m_axis_tready.
  - tvalid never depends on tready. Once tvalid is high, it is never withdrawn before acceptance.
- Element counter:
  - At elem_cnt == 0, when a word is loaded, latch eff_size = {layersize[LG_LAYERSIZE-1:2], 2'b00}. The low two bits are ignored.
  - layersize changes mid-vector have no effect.
  - eff_size == 0 means 2^LG_LAYERSIZE elements (natural counter wrap).
  - m_axis_tlast = (elem_cnt == eff_size-1). Comparison is modulo 2^LG_LAYERSIZE.
  - elem_cnt increments on each output accept and wraps to 0 after the tlast accept.
- Tlast check, evaluated on each input accept:
  - expected_last = (word_base + 4 == eff_size), where word_base is the elem_cnt of the word's element 0.
  - If s_axis_tlast != expected_last, set err_len = 1. It stays 1 until reset.
  - Output tlast always follows the counter, never s_axis_tlast.
- Simultaneous events: the load of a new word and the lane-3 output accept in the same cycle are both honoured. The counter advances exactly once.
- Width rule: data is passed bit-exact, with no sign extension or saturation. Lane order is LSB first.

Decomposition:
- Shared package kan_pkg:
  - Constant KAN_ELEM_W = 16.
  - Constant KAN_LANES = S_AXIS_DATAWIDTH / M_AXIS_DATAWIDTH.
  - Lane-index typedef of width clog2(KAN_LANES).
  - State enum {IDLE, EMIT}.
- Single module; no sub-module is warranted. The lane mux and counters are small.

Test Plan:
- layersize=8; beats 0x0004_0003_0002_0001 (tlast=0) then 0x0008_0007_0006_0005 (tlast=1); m_axis_tready=1 → outputs 1..8 on 8 consecutive cycles, tlast only on 8, s_axis_tready pulses once every 4 cycles, err_len=0.
- Same stimulus with m_axis_tready toggling 1,0,1,0 → identical output sequence; tdata/tlast stable during stalls; no element lost or duplicated.
- layersize=4; beat tlast=0 → err_len rises to 1 the cycle after accept and stays 1; output still shows tlast on element 4.
- Reset asserted after 2 elements of a layersize=8 vector → m_axis_tvalid=0 next cycle; a new vector after reset starts at element 0 with correct tlast after 8.
- layersize=8 changed to 4 after the first beat → current vector still ends at element 8; the next vector ends at 4.
- layersize=6 → treated as 4; tlast on every 4th element.
